// File: rtl/param_sync_fifo_if.sv
// Producer/consumer-facing bundle for param_sync_fifo.
// The FIFO connects through the slave modport, and the driving side through the master modport.
interface FIFO_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with configurable width and depth, almost-full/almost-empty thresholds,
// an occupancy count, and either a registered read or a first-word-fall-through read.
module param_sync_fifo #(
    parameter int FIFO_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int ALMOSTFULL_TH  = 7,
    parameter int ALMOSTEMPTY_TH = 1,
    parameter int FWFT           = 0
) (
    input  logic  clk,
    input  logic  rst,
    FIFO_if.slave f
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  empty_w, full_w, rd_ok, wr_ok;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(FIFO_DEPTH));
    assign rd_ok   = f.rd_en && !empty_w;
    // When full, a same-edge read frees the slot that the write then uses.
    assign wr_ok   = f.wr_en && (!full_w || rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= f.data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            wr_ack_q    <= wr_ok;
            overflow_q  <= f.wr_en && !wr_ok;
            underflow_q <= f.rd_en && !rd_ok;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is visible as soon as it is written. The output is 0 while empty, so unwritten RAM is never exposed.
            assign f.data_out = empty_w ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        dout_q <= '0;
                else if (rd_ok) dout_q <= mem[rd_ptr];
            end
            assign f.data_out = dout_q;
        end
    endgenerate

    assign f.wr_ack      = wr_ack_q;
    assign f.overflow    = overflow_q;
    assign f.underflow   = underflow_q;
    assign f.count       = count_q;
    assign f.empty       = empty_w;
    assign f.full        = full_w;
    assign f.almostfull  = (count_q >= CW'(ALMOSTFULL_TH));
    assign f.almostempty = (count_q <= CW'(ALMOSTEMPTY_TH));
endmodule
